// File: rtl/rr_grant_pkg.sv
// Shared sizes and state encoding for the 8-way round-robin grant encoder.
package rr_grant_pkg;
   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority pick: first set bit of req at or after ptr (mod 8).
module rr_pick8
   import rr_grant_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDX_W-1:0]     off;

   always_comb begin
      dbl = {req, req};
      // Shifting the doubled vector right by ptr yields a rotate, so bit 0 is requester ptr.
      rot = NUM_REQ'(dbl >> ptr);
      off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = IDX_W'(k);
      end
      idx = ptr + off;
      any = |req;
   end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over 8 requesters producing a registered 3-bit grant index,
// held until ack, request withdrawal or hold-counter timeout.
module rr_grant_encoder
   import rr_grant_pkg::*;
#(
   parameter int TIMEOUT = 16,
   localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               ack,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout,
   output logic               busy
);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             timeout_q, timeout_d;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             expire;
   logic             norm_rel;

   rr_pick8 u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign expire   = (TIMEOUT != 0) && (hold_cnt_q == CNT_W'(TIMEOUT - 1));
   assign norm_rel = ack || !req[gnt_idx_q];

   always_comb begin
      state_d    = state_q;
      gnt_idx_d  = gnt_idx_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gnt_idx_d  = pick_idx;
               hold_cnt_d = '0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            // A normal release wins over a coincident expiry, suppressing the pulse.
            if (norm_rel || expire) begin
               ptr_d      = gnt_idx_q + IDX_W'(1);
               hold_cnt_d = '0;
               state_d    = ST_IDLE;
               timeout_d  = !norm_rel;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_idx_q  <= '0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_idx_q  <= gnt_idx_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = (state_q == ST_GRANT);
   assign busy      = (state_q != ST_IDLE);
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder with a cycle-level reference model of the arbiter.
module tb_rr_grant_encoder;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       ack;
   logic [2:0] gnt_idx;
   logic       gnt_valid, timeout, busy;

   int errs   = 0;
   int checks = 0;

   rr_grant_encoder #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
      .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: grant age counts cycles the grant has been visible.
   bit       m_valid, m_to;
   int       m_idx, m_ptr, m_age;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_age = 0;
      end else if (!m_valid) begin
         m_to = 0;
         for (int k = 0; k < 8; k++) begin
            if (!m_valid && req[(m_ptr + k) % 8]) begin
               m_idx = (m_ptr + k) % 8;
               m_valid = 1;
               m_age = 1;
            end
         end
      end else begin
         bit rn, rt;
         rn = ack || !req[m_idx];
         rt = (TO != 0) && (m_age == TO);
         if (rn || rt) begin
            m_ptr   = (m_idx + 1) % 8;
            m_valid = 0;
            m_to    = !rn;
         end else begin
            m_age++;
            m_to = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("mdl_valid", int'(gnt_valid), int'(m_valid));
      chk("mdl_idx", int'(gnt_idx), m_idx);
      chk("mdl_timeout", int'(timeout), int'(m_to));
      chk("mdl_busy", int'(busy), int'(m_valid));
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; ack = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic exp_out(input string name, input int v, input int idx, input int to);
      chk({name, "_valid"}, int'(gnt_valid), v);
      if (v != 0) chk({name, "_idx"}, int'(gnt_idx), idx);
      chk({name, "_to"}, int'(timeout), to);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = '0; ack = 1'b0;
      step();
      chk("rst_valid", int'(gnt_valid), 0);
      chk("rst_idx", int'(gnt_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_to", int'(timeout), 0);
      rst_n = 1'b1;
      step();

      // Single requester, ack release, bubble, re-grant
      req = 8'h01; step();
      exp_out("t2_g", 1, 0, 0); ack = 1'b1; step();
      exp_out("t2_rel", 0, 0, 0); ack = 1'b0; step();
      exp_out("t2_regnt", 1, 0, 0); req = 8'h00; ack = 1'b1; step();
      ack = 1'b0; step();

      // Full request vector, ack every grant
      do_reset();
      req = 8'hFF; step();
      for (int i = 0; i < 9; i++) begin
         exp_out("t3_g", 1, i % 8, 0); ack = 1'b1; step();
         exp_out("t3_bub", 0, 0, 0); ack = 1'b0; step();
      end
      req = 8'h00; step();

      // Pointer wrap from 7
      do_reset();
      req = 8'h40; step();
      exp_out("t4_g6", 1, 6, 0); ack = 1'b1; req = 8'h03; step();
      exp_out("t4_b0", 0, 0, 0); ack = 1'b0; step();
      exp_out("t4_g0", 1, 0, 0); ack = 1'b1; step();
      exp_out("t4_b1", 0, 0, 0); ack = 1'b0; step();
      exp_out("t4_g1", 1, 1, 0); ack = 1'b1; step();
      exp_out("t4_b2", 0, 0, 0); ack = 1'b0; req = 8'h00; step();

      // Timeout expiry, then ack on the expiry cycle
      do_reset();
      req = 8'h09; step();
      for (int i = 0; i < 4; i++) begin
         exp_out("t5_hold0", 1, 0, 0); step();
      end
      exp_out("t5_pulse", 0, 0, 1); step();
      exp_out("t5_g3", 1, 3, 0); ack = 1'b1; step();
      exp_out("t5_b3", 0, 0, 0); ack = 1'b0; step();
      for (int i = 0; i < 3; i++) begin
         exp_out("t5_hold0b", 1, 0, 0); step();
      end
      exp_out("t5_last", 1, 0, 0); ack = 1'b1; step();
      exp_out("t5_nopulse", 0, 0, 0); ack = 1'b0; req = 8'h00; step();
      exp_out("t5_idle", 0, 0, 0);

      // Withdraw releases without pulse, ptr moves past withdrawn index
      do_reset();
      req = 8'h04; step();
      exp_out("t6_g2", 1, 2, 0); req = 8'h00; step();
      exp_out("t6_rel", 0, 0, 0); req = 8'h0C; step();
      exp_out("t6_g3", 1, 3, 0); ack = 1'b1; step();
      ack = 1'b0; step();
      exp_out("t6_g2b", 1, 2, 0); req = 8'h00; ack = 1'b1; step();
      ack = 1'b0; step();

      // Asynchronous reset mid-grant
      do_reset();
      req = 8'h20; step();
      exp_out("t1_g5", 1, 5, 0);
      chk("t1_busy", int'(busy), 1);
      rst_n = 1'b0; #1;
      chk("t1_rvalid", int'(gnt_valid), 0);
      chk("t1_ridx", int'(gnt_idx), 0);
      chk("t1_rto", int'(timeout), 0);
      chk("t1_rbusy", int'(busy), 0);
      step();
      rst_n = 1'b1; step();
      exp_out("t1_g5b", 1, 5, 0);
      req = 8'h00; ack = 1'b1; step();
      ack = 1'b0; step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
